vga_window_display: RTL and testbench
=====================================

Name: vga_window_display

Overview:
Parametrised VGA raster engine that generalises the team's fixed 640x480 centred-image display. It generates HS/VS/DE timing from per-field parameters and fetches pixels from an external frame RAM with configurable read latency. The image window has a runtime position, runtime integer scaling (1x/2x/4x) and a configurable border and background. All outputs are pipeline-aligned and sit directly in front of the 12-bit VGA DAC.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch/sync widths; H_TOTAL = sum of the four = 800
V_ACTIVE, 480, visible lines
V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch/sync widths; V_TOTAL = 525
IMG_W_LOG2, 8, image width = 2^8 = 256
IMG_H_LOG2, 7, image height = 2^7 = 128
RD_LAT, 1, frame-RAM read latency in cycles from addr to rgb (>= 0)
BORDER_W, 2, border thickness in pixels at the active-area edges; 0 disables the border
BORDER_COLOR, 12'hF00, border colour
BG_COLOR, 12'h000, colour of active area outside window and border

Ports:
clk25M  in  1  pixel clock
reset_n  in  1  synchronous active-low reset
x_pos  in  11  window left edge in pixels; latched at frame start
y_pos  in  11  window top edge in lines; latched at frame start
scale  in  2  0=1x, 1=2x, 2=4x, 3 treated as 2; latched at frame start
rgb  in  6  RAM pixel {B1,B0,G1,G0,R1,R0}, valid RD_LAT cycles after addr
addr  out  IMG_W_LOG2+IMG_H_LOG2  RAM address {iy, ix}, registered
VGA_HSYNC  out  1  active-low horizontal sync
VGA_VSYNC  out  1  active-low vertical sync
VGA_DE  out  1  active-video flag
frame_start  out  1  1-cycle pulse aligned with output pixel (0,0)
VGA_D  out  12  {R[3:0],G[3:0],B[3:0]}, registered

Behaviour:
- Counters: hcnt 0..H_TOTAL-1, wraps to 0. vcnt increments when hcnt==H_TOTAL-1 and wraps 0 after V_TOTAL-1. No off-by-one extra count.
- Sync at counter stage: hs low when H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC. vs low when V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC. Both fully synchronous, no combinational paths.
- Latch: x_pos/y_pos/scale are captured into shadow registers on the cycle hcnt==H_TOTAL-1 and vcnt==V_TOTAL-1. Mid-frame input changes have no effect until the next frame.
- Window: active = hcnt<H_ACTIVE && vcnt<V_ACTIVE. S = latched shift (0/1/2). win = active && hcnt>=xs && hcnt-xs < (2^IMG_W_LOG2<<S) && vcnt>=ys && vcnt-ys < (2^IMG_H_LOG2<<S). Comparisons use 12-bit unsigned. Any window part outside the active area is clipped.
- Image coordinates: ix=(hcnt-xs)>>S, iy=(vcnt-ys)>>S, truncated to IMG_W_LOG2/IMG_H_LOG2 bits.
- addr: registered; equals {iy,ix} when win, else 0.
- Pipeline: counter stage t -> addr at t+1 -> rgb at t+1+RD_LAT -> VGA_D at t+2+RD_LAT. LAT = RD_LAT+2. hs, vs, active, win, border flag and frame-start are delayed LAT cycles so VGA_D, HSYNC, VSYNC, DE and frame_start are mutually aligned.
- Colour priority at output stage: not active -> 12'h000. win -> R={r1,r1,r0,r0}, G={g1,g1,g0,g0}, B={b1,b1,b0,b0}. Border (hcnt<BORDER_W, hcnt>=H_ACTIVE-BORDER_W, vcnt<BORDER_W, or vcnt>=V_ACTIVE-BORDER_W) -> BORDER_COLOR. Otherwise BG_COLOR. Window overrides border.
- Reset (reset_n low at a clk edge): hcnt=vcnt=0, all delay-line stages cleared. Reset values: VGA_HSYNC=1, VGA_VSYNC=1, VGA_DE=0, frame_start=0, VGA_D=0, addr=0. Shadow registers reset to xs=(H_ACTIVE-2^IMG_W_LOG2)/2, ys=(V_ACTIVE-2^IMG_H_LOG2)/2, S=0.
- Mid-frame reset aborts the frame. The first cycle after release is counter (0,0). The first frame_start pulse comes LAT cycles later.

Test Plan:
- Defaults, release reset at cycle 0 -> VGA_HSYNC falls at cycle 659, rises at 755, period 800. VGA_VSYNC low for 1600 cycles starting at 490*800+3, period 420000. frame_start at cycle 3.
- RAM model rgb=addr[5:0], RD_LAT=1 -> output pixel (192,176) VGA_D=12'h000. Pixel (193,176) VGA_D=12'h300. Pixel (195,176) (rgb=000011) VGA_D=12'hF00. Pixel (191,176) VGA_D=BG_COLOR.
- Border check -> pixels (0,0), (639,479), (1,240) = 12'hF00. Pixel (2,2) = 12'h000. Pixel (640,0) = 12'h000 with VGA_DE=0.
- Set scale=1, x_pos=0, y_pos=0 mid-frame -> unchanged until next frame. Then pixels (0,0),(1,1) addr 0 (window overrides border). Pixel (2,0) addr 1. Pixel (511,255) addr {127,255}. Pixel (512,0) = border colour.
- x_pos=600, scale=0 -> h=600..639 fetch ix=0..39. h>=640 gives VGA_D=0, addr=0.
- reset_n low for 1 cycle at hcnt=300, vcnt=100 -> next cycle all outputs at reset values. Counters restart at (0,0). Timing matches the first scenario, re-based to the release edge.

Source files
------------

// File: rtl/vga_window_display.sv
// VGA raster engine: parametrised sync timing, a runtime-positioned and scaled image
// window fetched from an external frame RAM, plus border and background fill.
module vga_window_display #(
   parameter int          H_ACTIVE     = 640,
   parameter int          H_FP         = 16,
   parameter int          H_SYNC       = 96,
   parameter int          H_BP         = 48,
   parameter int          V_ACTIVE     = 480,
   parameter int          V_FP         = 10,
   parameter int          V_SYNC       = 2,
   parameter int          V_BP         = 33,
   parameter int          IMG_W_LOG2   = 8,
   parameter int          IMG_H_LOG2   = 7,
   parameter int          RD_LAT       = 1,
   parameter int          BORDER_W     = 2,
   parameter logic [11:0] BORDER_COLOR = 12'hF00,
   parameter logic [11:0] BG_COLOR     = 12'h000
) (
   input  logic                             clk25M,
   input  logic                             reset_n,
   input  logic [10:0]                      x_pos,
   input  logic [10:0]                      y_pos,
   input  logic [1:0]                       scale,
   input  logic [5:0]                       rgb,
   output logic [IMG_W_LOG2+IMG_H_LOG2-1:0] addr,
   output logic                             VGA_HSYNC,
   output logic                             VGA_VSYNC,
   output logic                             VGA_DE,
   output logic                             frame_start,
   output logic [11:0]                      VGA_D
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int LAT     = RD_LAT + 2;

   localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
   localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
   localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
   localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [11:0] BW       = 12'(BORDER_W);
   localparam logic [11:0] IMG_W    = 12'(2 ** IMG_W_LOG2);
   localparam logic [11:0] IMG_H    = 12'(2 ** IMG_H_LOG2);
   localparam logic [10:0] XS_RST   = 11'((H_ACTIVE - 2 ** IMG_W_LOG2) / 2);
   localparam logic [10:0] YS_RST   = 11'((V_ACTIVE - 2 ** IMG_H_LOG2) / 2);

   // hs/vs carry the asserted-sync sense so a cleared stage reads as idle
   typedef struct packed {
      logic hs;
      logic vs;
      logic active;
      logic win;
      logic border;
      logic fs;
   } flags_t;

   logic [11:0] hcnt, vcnt;
   logic [10:0] xs, ys;
   logic [1:0]  shift;

   always_ff @(posedge clk25M) begin
      if (!reset_n) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (hcnt == H_LAST) begin
         hcnt <= '0;
         vcnt <= (vcnt == V_LAST) ? 12'd0 : vcnt + 12'd1;
      end else begin
         hcnt <= hcnt + 12'd1;
      end
   end

   always_ff @(posedge clk25M) begin
      if (!reset_n) begin
         xs    <= XS_RST;
         ys    <= YS_RST;
         shift <= 2'd0;
      end else if (hcnt == H_LAST && vcnt == V_LAST) begin
         xs    <= x_pos;
         ys    <= y_pos;
         shift <= (scale == 2'd3) ? 2'd2 : scale;
      end
   end

   logic [11:0]           hoff, voff, w_span, h_span;
   logic [IMG_W_LOG2-1:0] ix;
   logic [IMG_H_LOG2-1:0] iy;
   logic                  active0, win0;
   flags_t                flags0;

   always_comb begin
      hoff    = hcnt - {1'b0, xs};
      voff    = vcnt - {1'b0, ys};
      w_span  = IMG_W << shift;
      h_span  = IMG_H << shift;
      ix      = IMG_W_LOG2'(hoff >> shift);
      iy      = IMG_H_LOG2'(voff >> shift);
      active0 = (hcnt < H_ACT) && (vcnt < V_ACT);
      win0    = active0 && (hcnt >= {1'b0, xs}) && (hoff < w_span)
                        && (vcnt >= {1'b0, ys}) && (voff < h_span);
      flags0.hs     = (hcnt >= HS_START) && (hcnt < HS_END);
      flags0.vs     = (vcnt >= VS_START) && (vcnt < VS_END);
      flags0.active = active0;
      flags0.win    = win0;
      flags0.border = active0 && ((hcnt < BW) || (hcnt + BW >= H_ACT) ||
                                  (vcnt < BW) || (vcnt + BW >= V_ACT));
      flags0.fs     = (hcnt == 12'd0) && (vcnt == 12'd0);
   end

   always_ff @(posedge clk25M) begin
      if (!reset_n) addr <= '0;
      else          addr <= win0 ? {iy, ix} : '0;
   end

   // LAT-1 stages here; the output register supplies the last one
   flags_t pipe [LAT-1];

   always_ff @(posedge clk25M) begin
      if (!reset_n) begin
         for (int i = 0; i < LAT - 1; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= flags0;
         for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
      end
   end

   flags_t      tail;
   logic [11:0] pix;

   always_comb begin
      tail = pipe[LAT-2];
      pix  = 12'h000;
      if (!tail.active)   pix = 12'h000;
      else if (tail.win)  pix = {rgb[1], rgb[1], rgb[0], rgb[0],
                                 rgb[3], rgb[3], rgb[2], rgb[2],
                                 rgb[5], rgb[5], rgb[4], rgb[4]};
      else if (tail.border) pix = BORDER_COLOR;
      else                pix = BG_COLOR;
   end

   always_ff @(posedge clk25M) begin
      if (!reset_n) begin
         VGA_HSYNC   <= 1'b1;
         VGA_VSYNC   <= 1'b1;
         VGA_DE      <= 1'b0;
         frame_start <= 1'b0;
         VGA_D       <= 12'h000;
      end else begin
         VGA_HSYNC   <= ~tail.hs;
         VGA_VSYNC   <= ~tail.vs;
         VGA_DE      <= tail.active;
         frame_start <= tail.fs;
         VGA_D       <= pix;
      end
   end

endmodule

// File: tb/tb_vga_window_display.sv
// Bench for vga_window_display: a shrunken-timing instance checked every cycle against
// a frame-level model, plus a default-timing instance checked at early landmarks.
module tb_vga_window_display;

   localparam int HA = 40, HFP = 4, HSW = 6, HBP = 5, HT = HA + HFP + HSW + HBP;
   localparam int VA = 24, VFP = 2, VSW = 2, VBP = 3, VT = VA + VFP + VSW + VBP;
   localparam int FT = HT * VT;
   localparam int IWL = 4, IHL = 3, IW = 16, IH = 8;
   localparam int RDL = 2, LAT = RDL + 2, BWD = 2;
   localparam logic [11:0] BORDER = 12'hF00, BG = 12'h05A;

   logic        clk, reset_n;
   logic [10:0] x_pos, y_pos;
   logic [1:0]  scale;
   logic [5:0]  rgb;
   logic [IWL+IHL-1:0] addr;
   logic        hs, vs, de, fs;
   logic [11:0] vd;

   logic [10:0] bx_pos, by_pos;
   logic [1:0]  bscale;
   logic [5:0]  brgb;
   logic [14:0] baddr;
   logic        bhs, bvs, bde, bfs;
   logic [11:0] bvd;

   vga_window_display #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .IMG_W_LOG2(IWL), .IMG_H_LOG2(IHL), .RD_LAT(RDL), .BORDER_W(BWD),
      .BORDER_COLOR(BORDER), .BG_COLOR(BG)
   ) dut (
      .clk25M(clk), .reset_n(reset_n), .x_pos(x_pos), .y_pos(y_pos), .scale(scale),
      .rgb(rgb), .addr(addr), .VGA_HSYNC(hs), .VGA_VSYNC(vs), .VGA_DE(de),
      .frame_start(fs), .VGA_D(vd)
   );

   vga_window_display dut_big (
      .clk25M(clk), .reset_n(reset_n), .x_pos(bx_pos), .y_pos(by_pos), .scale(bscale),
      .rgb(brgb), .addr(baddr), .VGA_HSYNC(bhs), .VGA_VSYNC(bvs), .VGA_DE(bde),
      .frame_start(bfs), .VGA_D(bvd)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int k       = 0;

   logic [5:0]  mem [IW*IH];
   int          fp_x[$], fp_y[$], fp_s[$];
   logic [IWL+IHL-1:0] addr_hist[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
      end
   endtask

   // reference model: everything derived from the frame position of counter time c
   function automatic int img_index(input int c);
      int h, v, n, xs, ys, s;
      h = c % HT; v = (c / HT) % VT; n = c / FT;
      xs = fp_x[n]; ys = fp_y[n];
      s = (fp_s[n] == 0) ? 0 : (fp_s[n] == 1) ? 1 : 2;
      if (h >= HA || v >= VA) return -1;
      if (h < xs || h >= xs + (IW << s) || v < ys || v >= ys + (IH << s)) return -1;
      return (((v - ys) >> s) % IH) * IW + (((h - xs) >> s) % IW);
   endfunction

   function automatic logic [11:0] exp_color(input int c);
      int h, v, idx, r, g, b;
      logic [5:0] px;
      h = c % HT; v = (c / HT) % VT;
      if (h >= HA || v >= VA) return 12'h000;
      idx = img_index(c);
      if (idx >= 0) begin
         px = mem[idx];
         r = 12 * px[1] + 3 * px[0];
         g = 12 * px[3] + 3 * px[2];
         b = 12 * px[5] + 3 * px[4];
         return 12'((r << 8) | (g << 4) | b);
      end
      if (h < BWD || h >= HA - BWD || v < BWD || v >= VA - BWD) return BORDER;
      return BG;
   endfunction

   task automatic check_small();
      int c, h, v, idx;
      c = k - 1;
      idx = (c < 0) ? -1 : img_index(c);
      check_eq("addr", 32'(addr), (idx < 0) ? 32'd0 : 32'(idx));
      c = k - LAT;
      if (c < 0) begin
         check_eq("hsync_rst", 32'(hs), 32'd1);
         check_eq("vsync_rst", 32'(vs), 32'd1);
         check_eq("de_rst", 32'(de), 32'd0);
         check_eq("fs_rst", 32'(fs), 32'd0);
         check_eq("d_rst", 32'(vd), 32'd0);
      end else begin
         h = c % HT; v = (c / HT) % VT;
         check_eq("hsync", 32'(hs), (h >= HA + HFP && h < HA + HFP + HSW) ? 32'd0 : 32'd1);
         check_eq("vsync", 32'(vs), (v >= VA + VFP && v < VA + VFP + VSW) ? 32'd0 : 32'd1);
         check_eq("de", 32'(de), (h < HA && v < VA) ? 32'd1 : 32'd0);
         check_eq("fs", 32'(fs), (h == 0 && v == 0) ? 32'd1 : 32'd0);
         check_eq("vga_d", 32'(vd), 32'(exp_color(c)));
      end
   endtask

   // default-timing landmarks, cycle counted from the release edge
   task automatic check_big();
      case (k)
         2:    check_eq("big_fs_pre", 32'(bfs), 32'd0);
         3: begin
            check_eq("big_fs", 32'(bfs), 32'd1);
            check_eq("big_de00", 32'(bde), 32'd1);
            check_eq("big_d00", 32'(bvd), 32'hF00);
         end
         4:    check_eq("big_fs_post", 32'(bfs), 32'd0);
         5:    check_eq("big_d20", 32'(bvd), 32'hF00);
         642: begin
            check_eq("big_d639", 32'(bvd), 32'hF00);
            check_eq("big_de639", 32'(bde), 32'd1);
         end
         643: begin
            check_eq("big_d640", 32'(bvd), 32'h000);
            check_eq("big_de640", 32'(bde), 32'd0);
         end
         658:  check_eq("big_hs658", 32'(bhs), 32'd1);
         659: begin
            check_eq("big_hs659", 32'(bhs), 32'd0);
            check_eq("big_vs659", 32'(bvs), 32'd1);
         end
         754:  check_eq("big_hs754", 32'(bhs), 32'd0);
         755:  check_eq("big_hs755", 32'(bhs), 32'd1);
         804:  check_eq("big_d11", 32'(bvd), 32'hF00);
         1458: check_eq("big_hs1458", 32'(bhs), 32'd1);
         1459: check_eq("big_hs1459", 32'(bhs), 32'd0);
         1605: begin
            check_eq("big_d22", 32'(bvd), 32'h000);
            check_eq("big_de22", 32'(bde), 32'd1);
         end
         default: ;
      endcase
   endtask

   task automatic model_reset();
      fp_x.delete(); fp_y.delete(); fp_s.delete(); addr_hist.delete();
      fp_x.push_back((HA - IW) / 2);
      fp_y.push_back((VA - IH) / 2);
      fp_s.push_back(0);
   endtask

   initial begin
      bit did_reset, rst_pending;
      int reset_at;
      did_reset = 0; rst_pending = 0;
      reset_at = 3 * FT + 10 * HT + 30;
      for (int i = 0; i < IW * IH; i++) mem[i] = 6'($urandom);
      reset_n = 1'b0;
      x_pos = 11'd20; y_pos = 11'd3; scale = 2'd2; rgb = 6'd0;
      bx_pos = 11'd0; by_pos = 11'd0; bscale = 2'd1; brgb = 6'd0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      k = 0;
      while (!(did_reset && k == 4 * FT + 10)) begin
         check_small();
         if (!did_reset) check_big();
         // RAM model: answer RDL cycles after the address appeared
         addr_hist.push_back(addr);
         if (addr_hist.size() > RDL + 1) void'(addr_hist.pop_front());
         rgb = (addr_hist.size() == RDL + 1) ? mem[addr_hist[0]] : 6'd0;
         if (!did_reset && k == FT / 2) begin
            x_pos = 11'd0; y_pos = 11'd0; scale = 2'd1;
         end else if (!did_reset && k == FT + FT / 2) begin
            x_pos = 11'd30; y_pos = 11'd5; scale = 2'd0;
         end else if ((did_reset || k >= 2 * FT) && $urandom_range(0, 99) == 0) begin
            x_pos = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 2047))
                                               : 11'($urandom_range(0, 45));
            y_pos = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 2047))
                                               : 11'($urandom_range(0, 28));
            scale = 2'($urandom_range(0, 3));
         end
         if (!did_reset && k == reset_at) begin
            reset_n = 1'b0;
            rst_pending = 1;
         end else if ((k + 1) % FT == 0) begin
            fp_x.push_back(int'(x_pos));
            fp_y.push_back(int'(y_pos));
            fp_s.push_back(int'(scale));
         end
         @(posedge clk);
         #1;
         if (rst_pending) begin
            rst_pending = 0;
            did_reset = 1;
            reset_n = 1'b1;
            model_reset();
            k = 0;
         end else begin
            k++;
         end
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
